temp_window_accum: RTL and testbench
====================================

Name: temp_window_accum

Overview:
- Upstream stage of the 16-bit combinational divider in the temperature-monitoring path.
- Collects a programmable window of raw temperature samples and accumulates their sum, count, minimum and maximum.
- Presents sum/count as the divider's dividend (N) and divisor (D) so the divider yields the window average.
- Results are held in a registered result buffer with a valid/ack handshake and overrun detection.

Parameters:
- SAMPLE_W, 10, width of one unsigned temperature sample.
- WIN_W, 6, width of the window-length input; maximum window is 2^WIN_W-1 = 63 samples.
- Constraint: (2^SAMPLE_W-1)*(2^WIN_W-1) must fit in 16 bits. The defaults give 1023*63 = 64449, which fits.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 1 = collect windows continuously, 0 = stop and discard the partial window.
- win_len  in  WIN_W  samples per window; a value of 0 is treated as 1.
- s_data  in  SAMPLE_W  sample value.
- s_valid  in  1  sample present.
- s_ready  out  1  sample accepted when s_valid & s_ready on a rising edge.
- sum_o  out  16  window sum, zero-extended; feeds divider N.
- cnt_o  out  16  window sample count, zero-extended; feeds divider D.
- min_o  out  SAMPLE_W  smallest sample in the window.
- max_o  out  SAMPLE_W  largest sample in the window.
- res_valid  out  1  result registers hold an unconsumed result.
- res_ack  in  1  consumer has taken the result.
- overrun  out  1  sticky flag: a result was overwritten before it was acked.
- clr_ovr  in  1  clears overrun.

Behaviour:
- Reset (rst=1 at edge):
  - State = IDLE.
  - Accumulators: sum = 0, cnt = 0, min = all ones, max = 0.
  - All outputs = 0: sum_o, cnt_o, min_o, max_o, res_valid, overrun. s_ready = 0.
  - rst overrides every other input. Reset mid-window discards all partial data.
- States:
  - IDLE: s_ready = 0. When en=1, latch win_len (0 becomes 1) into len_q, clear the accumulators, go to ACCUM.
  - ACCUM: s_ready = en (combinational).
    - en=0: go to IDLE; the partial window is discarded and the result registers are untouched. A sample offered in that cycle is not accepted.
    - Accept (s_valid & s_ready): sum += s_data, cnt += 1, min = min(min, s_data), max = max(max, s_data).
- Window completion: the accept where cnt+1 == len_q.
  - At that same edge, sum_o/cnt_o/min_o/max_o load the values including that sample.
  - res_valid = 1 from the next cycle (latency 1 cycle from the last accept).
  - Accumulators reset to their initial values and len_q relatches the current win_len.
  - State stays ACCUM; the next sample can be accepted on the very next cycle, so no samples are dropped.
- win_len changes mid-window have no effect until the next window start.
- Result handshake:
  - res_ack with res_valid=1 clears res_valid at that edge; res_ack with res_valid=0 is ignored.
  - Outputs stay stable while res_valid=1, except on overwrite.
- Simultaneous events:
  - Completion with res_valid=1 and res_ack=0: new result overwrites, res_valid stays 1, overrun <= 1.
  - Completion with res_valid=1 and res_ack=1: new result loads, res_valid stays 1, no overrun.
  - clr_ovr together with an overrun event: the set wins, overrun = 1.
- Arithmetic: unsigned only. The 16-bit sum cannot wrap within the parameter constraint. cnt_o is never 0 when res_valid=1, so the downstream divide is always safe.
- Window of 1: every accepted sample completes a window; sum_o = min_o = max_o = sample and cnt_o = 1.

Test Plan:
- Reset, then en=1, win_len=4, samples 100,200,300,400 on consecutive cycles -> res_valid=1 the cycle after the 4th accept; sum_o=1000, cnt_o=4, min_o=100, max_o=400; divider output Q=250.
- win_len=63, 63 samples of 1023 -> sum_o=64449, cnt_o=63, no wrap; min_o=max_o=1023.
- win_len=2, 6 continuous samples 10,20,30,40,50,60 with no res_ack -> results (30,2) then (70,2) then (110,2); overrun=1 after the 2nd completion; clr_ovr -> overrun=0.
- win_len=2, res_ack asserted on the same edge as the completion of window 2 -> result (70,2), res_valid=1, overrun=0.
- win_len=4, 2 samples accepted, then en=0 for 1 cycle, then en=1 and 4 samples 5,5,5,5 -> s_ready=0 during the en=0 cycle; result sum_o=20, cnt_o=4 (partial window discarded); earlier result registers unchanged before that.
- win_len=0, sample 7 -> cnt_o=1, sum_o=7. Then rst asserted mid-window -> all outputs 0 and s_ready=0 next cycle.

Source files
------------

// File: rtl/temp_window_accum_if.sv
// Sample stream, window control and result/handshake bundle for temp_window_accum.
// The slave modport is the accumulator side; the master modport is the sample source and result consumer.
interface temp_window_accum_if #(
    parameter int SAMPLE_W = 10,
    parameter int WIN_W    = 6
);
    logic                en;
    logic [WIN_W-1:0]    win_len;
    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic [15:0]         sum_o;
    logic [15:0]         cnt_o;
    logic [SAMPLE_W-1:0] min_o;
    logic [SAMPLE_W-1:0] max_o;
    logic                res_valid;
    logic                res_ack;
    logic                overrun;
    logic                clr_ovr;

    modport slave (
        input  en, win_len, s_data, s_valid, res_ack, clr_ovr,
        output s_ready, sum_o, cnt_o, min_o, max_o, res_valid, overrun
    );

    modport master (
        output en, win_len, s_data, s_valid, res_ack, clr_ovr,
        input  s_ready, sum_o, cnt_o, min_o, max_o, res_valid, overrun
    );
endinterface

// File: rtl/temp_window_accum.sv
// Windowed sum/count/min/max of temperature samples; result registered 1 cycle after the last accept.
// s_ready follows en while collecting; an unacked result is overwritten and flagged as overrun.
module temp_window_accum #(
    parameter int SAMPLE_W = 10,
    parameter int WIN_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    temp_window_accum_if.slave    bus
);
    localparam int SUM_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WIN_W-1:0]    len_q, len_d;

    logic [SUM_W-1:0]    acc_sum_q, acc_sum_d;
    logic [WIN_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [SAMPLE_W-1:0] acc_min_q, acc_min_d;
    logic [SAMPLE_W-1:0] acc_max_q, acc_max_d;

    logic [SUM_W-1:0]    res_sum_q, res_sum_d;
    logic [WIN_W-1:0]    res_cnt_q, res_cnt_d;
    logic [SAMPLE_W-1:0] res_min_q, res_min_d;
    logic [SAMPLE_W-1:0] res_max_q, res_max_d;
    logic                res_vld_q, res_vld_d;
    logic                ovr_q, ovr_d;

    logic                s_rdy;
    logic                accept;
    logic                win_done;
    logic                ovr_set;
    logic [WIN_W-1:0]    len_eff;
    logic [WIN_W:0]      cnt_inc;
    logic [SUM_W-1:0]    sum_new;
    logic [SAMPLE_W-1:0] min_new;
    logic [SAMPLE_W-1:0] max_new;

    // A programmed length of 0 behaves as a single-sample window.
    assign len_eff = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;

    assign cnt_inc = {1'b0, acc_cnt_q} + (WIN_W + 1)'(1);
    assign sum_new = acc_sum_q + SUM_W'(bus.s_data);
    assign min_new = (bus.s_data < acc_min_q) ? bus.s_data : acc_min_q;
    assign max_new = (bus.s_data > acc_max_q) ? bus.s_data : acc_max_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_sum_d = acc_sum_q;
        acc_cnt_d = acc_cnt_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        res_sum_d = res_sum_q;
        res_cnt_d = res_cnt_q;
        res_min_d = res_min_q;
        res_max_d = res_max_q;
        res_vld_d = res_vld_q;
        ovr_d     = ovr_q;
        s_rdy     = 1'b0;
        accept    = 1'b0;
        win_done  = 1'b0;
        ovr_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    len_d     = len_eff;
                    acc_sum_d = '0;
                    acc_cnt_d = '0;
                    acc_min_d = '1;
                    acc_max_d = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (!bus.en) begin
                    // Drop the partial window; the result buffer keeps its contents.
                    acc_sum_d = '0;
                    acc_cnt_d = '0;
                    acc_min_d = '1;
                    acc_max_d = '0;
                    state_d   = IDLE;
                end else begin
                    s_rdy  = 1'b1;
                    accept = bus.s_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            win_done = (cnt_inc == {1'b0, len_q});
            if (win_done) begin
                res_sum_d = sum_new;
                res_cnt_d = cnt_inc[WIN_W-1:0];
                res_min_d = min_new;
                res_max_d = max_new;
                acc_sum_d = '0;
                acc_cnt_d = '0;
                acc_min_d = '1;
                acc_max_d = '0;
                len_d     = len_eff;
            end else begin
                acc_sum_d = sum_new;
                acc_cnt_d = cnt_inc[WIN_W-1:0];
                acc_min_d = min_new;
                acc_max_d = max_new;
            end
        end

        // An ack in the completion cycle consumes the old result, so no overrun.
        if (win_done) begin
            res_vld_d = 1'b1;
            ovr_set   = res_vld_q && !bus.res_ack;
        end else if (bus.res_ack && res_vld_q) begin
            res_vld_d = 1'b0;
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
            acc_min_q <= '1;
            acc_max_q <= '0;
            res_sum_q <= '0;
            res_cnt_q <= '0;
            res_min_q <= '0;
            res_max_q <= '0;
            res_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            acc_sum_q <= acc_sum_d;
            acc_cnt_q <= acc_cnt_d;
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
            res_sum_q <= res_sum_d;
            res_cnt_q <= res_cnt_d;
            res_min_q <= res_min_d;
            res_max_q <= res_max_d;
            res_vld_q <= res_vld_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.s_ready   = s_rdy;
    assign bus.sum_o     = res_sum_q;
    assign bus.cnt_o     = SUM_W'(res_cnt_q);
    assign bus.min_o     = res_min_q;
    assign bus.max_o     = res_max_q;
    assign bus.res_valid = res_vld_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_temp_window_accum.sv
// Scoreboard bench for temp_window_accum: a reference model pushes each expected window result.
// The result is popped and compared when the DUT presents it.
module tb_temp_window_accum;
    localparam int SW = 10;
    localparam int WW = 6;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    temp_window_accum_if #(.SAMPLE_W(SW), .WIN_W(WW)) bus();

    temp_window_accum #(.SAMPLE_W(SW), .WIN_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [15:0]   sum;
        logic [15:0]   cnt;
        logic [SW-1:0] mn;
        logic [SW-1:0] mx;
    } res_t;

    res_t exp_q[$];
    res_t last_res;

    int total = 0;
    int bad   = 0;

    int m_len, m_sum, m_cnt, m_min, m_max, m_rv, m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_sum = 0;
        m_cnt = 0;
        m_min = (1 << SW) - 1;
        m_max = 0;
    endtask

    function automatic int eff_len();
        return (bus.win_len == '0) ? 1 : int'(bus.win_len);
    endfunction

    task automatic chk_held();
        chk("held_sum", 32'(bus.sum_o), 32'(last_res.sum));
        chk("held_cnt", 32'(bus.cnt_o), 32'(last_res.cnt));
        chk("held_min", 32'(bus.min_o), 32'(last_res.mn));
        chk("held_max", 32'(bus.max_o), 32'(last_res.mx));
    endtask

    // One clock edge; the model tracks what the DUT should do at that edge.
    task automatic tick(input bit take, input bit ack, input bit clr);
        res_t r;
        bit   done;
        bit   set;
        int   v;
        v           = int'(bus.s_data);
        bus.res_ack = ack;
        bus.clr_ovr = clr;
        @(posedge clk);
        #1;
        bus.res_ack = 1'b0;
        bus.clr_ovr = 1'b0;
        bus.s_valid = 1'b0;
        done = 1'b0;
        if (take) begin
            m_sum += v;
            m_cnt++;
            if (v < m_min) m_min = v;
            if (v > m_max) m_max = v;
            if (m_cnt == m_len) begin
                done  = 1'b1;
                r.sum = 16'(m_sum);
                r.cnt = 16'(m_cnt);
                r.mn  = SW'(m_min);
                r.mx  = SW'(m_max);
                exp_q.push_back(r);
                model_clear();
                m_len = eff_len();
            end
        end
        set = done && (m_rv != 0) && !ack;
        if (set)      m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (done)     m_rv = 1;
        else if (ack) m_rv = 0;
        chk("res_valid", 32'(bus.res_valid), m_rv);
        chk("overrun", 32'(bus.overrun), m_ovr);
        if (done) begin
            r = exp_q.pop_front();
            last_res = r;
            chk_held();
        end
    endtask

    task automatic send(input int v, input bit ack);
        bus.s_data  = SW'(v);
        bus.s_valid = 1'b1;
        #1;
        chk("s_ready", 32'(bus.s_ready), 1);
        tick(1'b1, ack, 1'b0);
    endtask

    task automatic start(input int len);
        bus.win_len = WW'(len);
        bus.en      = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        m_len = eff_len();
        model_clear();
    endtask

    // Leave ACCUM with a sample offered; it must not be taken.
    task automatic stop();
        bus.en      = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = SW'(333);
        #1;
        chk("s_ready_off", 32'(bus.s_ready), 0);
        tick(1'b0, 1'b0, 1'b0);
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.win_len = '0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.res_ack = 1'b0;
        bus.clr_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 32'(bus.sum_o), 0);
        chk("rst_cnt", 32'(bus.cnt_o), 0);
        chk("rst_min", 32'(bus.min_o), 0);
        chk("rst_max", 32'(bus.max_o), 0);
        chk("rst_vld", 32'(bus.res_valid), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
        chk("rst_rdy", 32'(bus.s_ready), 0);
        rst   = 1'b0;
        m_rv  = 0;
        m_ovr = 0;
        m_len = 1;
        model_clear();

        // Window of 4; a mid-window length change only applies to the next window.
        start(4);
        send(100, 1'b0);
        bus.win_len = WW'(9);
        send(200, 1'b0);
        send(300, 1'b0);
        send(400, 1'b0);
        chk("div_q", (bus.cnt_o != 0) ? 32'(bus.sum_o / bus.cnt_o) : 32'hFFFF_FFFF, 250);
        tick(1'b0, 1'b1, 1'b0);
        chk_held();
        stop();

        // Largest window, largest samples: no wrap.
        start(63);
        for (int i = 0; i < 63; i++) send(1023, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        stop();

        // Back-to-back windows of 2 without ack: overwrite and overrun.
        start(2);
        for (int i = 1; i <= 6; i++) send(i * 10, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        stop();

        // Ack coincides with the second completion: no overrun.
        start(2);
        send(10, 1'b0);
        send(20, 1'b0);
        send(30, 1'b0);
        send(40, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        stop();

        // Partial window dropped by a one-cycle en=0.
        start(4);
        send(1, 1'b0);
        send(2, 1'b0);
        stop();
        chk_held();
        start(4);
        for (int i = 0; i < 4; i++) send(5, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        stop();

        // Window length 0 behaves as 1, then reset while collecting.
        start(0);
        send(7, 1'b0);
        send(9, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = SW'(3);
        rst         = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_sum", 32'(bus.sum_o), 0);
        chk("mid_rst_cnt", 32'(bus.cnt_o), 0);
        chk("mid_rst_min", 32'(bus.min_o), 0);
        chk("mid_rst_max", 32'(bus.max_o), 0);
        chk("mid_rst_vld", 32'(bus.res_valid), 0);
        chk("mid_rst_ovr", 32'(bus.overrun), 0);
        chk("mid_rst_rdy", 32'(bus.s_ready), 0);
        bus.en      = 1'b0;
        bus.s_valid = 1'b0;
        rst         = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
